// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES SubBytes+ShiftRows engines (forward and
//   inverse). Holds the FSM state encoding, the byte/column index types and
//   constants, and the byte-index helpers used for the ShiftRows mapping.
//
//   State byte order follows FIPS-197: byte 0 sits at [127:120], column c is
//   bytes 4c..4c+3 and row r of column c is byte 4c+r. A byte index is
//   therefore simply {col, row}.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_BYTES = NUM_ROWS * NUM_COLS;
  localparam int STATE_W   = NUM_BYTES * BYTE_W;

  // 2-bit row/column index and 4-bit byte index.
  typedef logic [1:0] idx2_t;
  typedef logic [3:0] byte_idx_t;

  localparam idx2_t FIRST_COL = 2'd0;
  localparam idx2_t LAST_COL  = 2'd3;

  // Packed state: element [15] is byte 0 (bits [127:120]), element [0] is
  // byte 15. Use slot() to turn a FIPS byte index into an element index.
  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } fsm_state_e;

  // FIPS byte index of (row, col).
  function automatic byte_idx_t byte_idx(idx2_t row, idx2_t col);
    return {col, row};
  endfunction

  // Destination byte index after ShiftRows: row r rotates left by r, so the
  // byte at (r, c) lands at (r, (c - r) mod 4). The 2-bit subtraction wraps
  // for free. The inverse engine calls this with the roles swapped.
  function automatic byte_idx_t shiftrows_idx(idx2_t row, idx2_t col);
    idx2_t dst_col;
    dst_col = col - row;
    return byte_idx(row, dst_col);
  endfunction

  // Element index inside aes_state_t for a FIPS byte index.
  function automatic byte_idx_t slot(byte_idx_t b);
    return byte_idx_t'(NUM_BYTES - 1) - b;
  endfunction

endpackage

// File: rtl/aes_subshift_enc_if.sv
// ---------------------------------------------------------------------------
// aes_subshift_enc_if
//   Valid/ready bundle around the SubBytes+ShiftRows engine.
//     in_valid/in_ready/in_data    : input state handshake (128-bit state)
//     out_valid/out_ready/out_data : result handshake (128-bit state)
//     busy                         : engine is not idle
//   master : the side that supplies states and consumes results
//   slave  : the engine itself
// ---------------------------------------------------------------------------
interface aes_subshift_enc_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

endinterface

// File: rtl/sbox_fwd.sv
// ---------------------------------------------------------------------------
// sbox_fwd
//   Registered forward AES S-box: q holds SubBytes(a) one cycle after a is
//   presented.
//     clk : clock, rising edge
//     a   : byte to substitute
//     q   : registered S-box output
// ---------------------------------------------------------------------------
module sbox_fwd (
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] q
);

  logic [7:0] q_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    q_d = 8'h00;
    case (a)
      8'h00: q_d = 8'h63; 8'h01: q_d = 8'h7c; 8'h02: q_d = 8'h77; 8'h03: q_d = 8'h7b; 8'h04: q_d = 8'hf2; 8'h05: q_d = 8'h6b; 8'h06: q_d = 8'h6f; 8'h07: q_d = 8'hc5;
      8'h08: q_d = 8'h30; 8'h09: q_d = 8'h01; 8'h0a: q_d = 8'h67; 8'h0b: q_d = 8'h2b; 8'h0c: q_d = 8'hfe; 8'h0d: q_d = 8'hd7; 8'h0e: q_d = 8'hab; 8'h0f: q_d = 8'h76;
      8'h10: q_d = 8'hca; 8'h11: q_d = 8'h82; 8'h12: q_d = 8'hc9; 8'h13: q_d = 8'h7d; 8'h14: q_d = 8'hfa; 8'h15: q_d = 8'h59; 8'h16: q_d = 8'h47; 8'h17: q_d = 8'hf0;
      8'h18: q_d = 8'had; 8'h19: q_d = 8'hd4; 8'h1a: q_d = 8'ha2; 8'h1b: q_d = 8'haf; 8'h1c: q_d = 8'h9c; 8'h1d: q_d = 8'ha4; 8'h1e: q_d = 8'h72; 8'h1f: q_d = 8'hc0;
      8'h20: q_d = 8'hb7; 8'h21: q_d = 8'hfd; 8'h22: q_d = 8'h93; 8'h23: q_d = 8'h26; 8'h24: q_d = 8'h36; 8'h25: q_d = 8'h3f; 8'h26: q_d = 8'hf7; 8'h27: q_d = 8'hcc;
      8'h28: q_d = 8'h34; 8'h29: q_d = 8'ha5; 8'h2a: q_d = 8'he5; 8'h2b: q_d = 8'hf1; 8'h2c: q_d = 8'h71; 8'h2d: q_d = 8'hd8; 8'h2e: q_d = 8'h31; 8'h2f: q_d = 8'h15;
      8'h30: q_d = 8'h04; 8'h31: q_d = 8'hc7; 8'h32: q_d = 8'h23; 8'h33: q_d = 8'hc3; 8'h34: q_d = 8'h18; 8'h35: q_d = 8'h96; 8'h36: q_d = 8'h05; 8'h37: q_d = 8'h9a;
      8'h38: q_d = 8'h07; 8'h39: q_d = 8'h12; 8'h3a: q_d = 8'h80; 8'h3b: q_d = 8'he2; 8'h3c: q_d = 8'heb; 8'h3d: q_d = 8'h27; 8'h3e: q_d = 8'hb2; 8'h3f: q_d = 8'h75;
      8'h40: q_d = 8'h09; 8'h41: q_d = 8'h83; 8'h42: q_d = 8'h2c; 8'h43: q_d = 8'h1a; 8'h44: q_d = 8'h1b; 8'h45: q_d = 8'h6e; 8'h46: q_d = 8'h5a; 8'h47: q_d = 8'ha0;
      8'h48: q_d = 8'h52; 8'h49: q_d = 8'h3b; 8'h4a: q_d = 8'hd6; 8'h4b: q_d = 8'hb3; 8'h4c: q_d = 8'h29; 8'h4d: q_d = 8'he3; 8'h4e: q_d = 8'h2f; 8'h4f: q_d = 8'h84;
      8'h50: q_d = 8'h53; 8'h51: q_d = 8'hd1; 8'h52: q_d = 8'h00; 8'h53: q_d = 8'hed; 8'h54: q_d = 8'h20; 8'h55: q_d = 8'hfc; 8'h56: q_d = 8'hb1; 8'h57: q_d = 8'h5b;
      8'h58: q_d = 8'h6a; 8'h59: q_d = 8'hcb; 8'h5a: q_d = 8'hbe; 8'h5b: q_d = 8'h39; 8'h5c: q_d = 8'h4a; 8'h5d: q_d = 8'h4c; 8'h5e: q_d = 8'h58; 8'h5f: q_d = 8'hcf;
      8'h60: q_d = 8'hd0; 8'h61: q_d = 8'hef; 8'h62: q_d = 8'haa; 8'h63: q_d = 8'hfb; 8'h64: q_d = 8'h43; 8'h65: q_d = 8'h4d; 8'h66: q_d = 8'h33; 8'h67: q_d = 8'h85;
      8'h68: q_d = 8'h45; 8'h69: q_d = 8'hf9; 8'h6a: q_d = 8'h02; 8'h6b: q_d = 8'h7f; 8'h6c: q_d = 8'h50; 8'h6d: q_d = 8'h3c; 8'h6e: q_d = 8'h9f; 8'h6f: q_d = 8'ha8;
      8'h70: q_d = 8'h51; 8'h71: q_d = 8'ha3; 8'h72: q_d = 8'h40; 8'h73: q_d = 8'h8f; 8'h74: q_d = 8'h92; 8'h75: q_d = 8'h9d; 8'h76: q_d = 8'h38; 8'h77: q_d = 8'hf5;
      8'h78: q_d = 8'hbc; 8'h79: q_d = 8'hb6; 8'h7a: q_d = 8'hda; 8'h7b: q_d = 8'h21; 8'h7c: q_d = 8'h10; 8'h7d: q_d = 8'hff; 8'h7e: q_d = 8'hf3; 8'h7f: q_d = 8'hd2;
      8'h80: q_d = 8'hcd; 8'h81: q_d = 8'h0c; 8'h82: q_d = 8'h13; 8'h83: q_d = 8'hec; 8'h84: q_d = 8'h5f; 8'h85: q_d = 8'h97; 8'h86: q_d = 8'h44; 8'h87: q_d = 8'h17;
      8'h88: q_d = 8'hc4; 8'h89: q_d = 8'ha7; 8'h8a: q_d = 8'h7e; 8'h8b: q_d = 8'h3d; 8'h8c: q_d = 8'h64; 8'h8d: q_d = 8'h5d; 8'h8e: q_d = 8'h19; 8'h8f: q_d = 8'h73;
      8'h90: q_d = 8'h60; 8'h91: q_d = 8'h81; 8'h92: q_d = 8'h4f; 8'h93: q_d = 8'hdc; 8'h94: q_d = 8'h22; 8'h95: q_d = 8'h2a; 8'h96: q_d = 8'h90; 8'h97: q_d = 8'h88;
      8'h98: q_d = 8'h46; 8'h99: q_d = 8'hee; 8'h9a: q_d = 8'hb8; 8'h9b: q_d = 8'h14; 8'h9c: q_d = 8'hde; 8'h9d: q_d = 8'h5e; 8'h9e: q_d = 8'h0b; 8'h9f: q_d = 8'hdb;
      8'ha0: q_d = 8'he0; 8'ha1: q_d = 8'h32; 8'ha2: q_d = 8'h3a; 8'ha3: q_d = 8'h0a; 8'ha4: q_d = 8'h49; 8'ha5: q_d = 8'h06; 8'ha6: q_d = 8'h24; 8'ha7: q_d = 8'h5c;
      8'ha8: q_d = 8'hc2; 8'ha9: q_d = 8'hd3; 8'haa: q_d = 8'hac; 8'hab: q_d = 8'h62; 8'hac: q_d = 8'h91; 8'had: q_d = 8'h95; 8'hae: q_d = 8'he4; 8'haf: q_d = 8'h79;
      8'hb0: q_d = 8'he7; 8'hb1: q_d = 8'hc8; 8'hb2: q_d = 8'h37; 8'hb3: q_d = 8'h6d; 8'hb4: q_d = 8'h8d; 8'hb5: q_d = 8'hd5; 8'hb6: q_d = 8'h4e; 8'hb7: q_d = 8'ha9;
      8'hb8: q_d = 8'h6c; 8'hb9: q_d = 8'h56; 8'hba: q_d = 8'hf4; 8'hbb: q_d = 8'hea; 8'hbc: q_d = 8'h65; 8'hbd: q_d = 8'h7a; 8'hbe: q_d = 8'hae; 8'hbf: q_d = 8'h08;
      8'hc0: q_d = 8'hba; 8'hc1: q_d = 8'h78; 8'hc2: q_d = 8'h25; 8'hc3: q_d = 8'h2e; 8'hc4: q_d = 8'h1c; 8'hc5: q_d = 8'ha6; 8'hc6: q_d = 8'hb4; 8'hc7: q_d = 8'hc6;
      8'hc8: q_d = 8'he8; 8'hc9: q_d = 8'hdd; 8'hca: q_d = 8'h74; 8'hcb: q_d = 8'h1f; 8'hcc: q_d = 8'h4b; 8'hcd: q_d = 8'hbd; 8'hce: q_d = 8'h8b; 8'hcf: q_d = 8'h8a;
      8'hd0: q_d = 8'h70; 8'hd1: q_d = 8'h3e; 8'hd2: q_d = 8'hb5; 8'hd3: q_d = 8'h66; 8'hd4: q_d = 8'h48; 8'hd5: q_d = 8'h03; 8'hd6: q_d = 8'hf6; 8'hd7: q_d = 8'h0e;
      8'hd8: q_d = 8'h61; 8'hd9: q_d = 8'h35; 8'hda: q_d = 8'h57; 8'hdb: q_d = 8'hb9; 8'hdc: q_d = 8'h86; 8'hdd: q_d = 8'hc1; 8'hde: q_d = 8'h1d; 8'hdf: q_d = 8'h9e;
      8'he0: q_d = 8'he1; 8'he1: q_d = 8'hf8; 8'he2: q_d = 8'h98; 8'he3: q_d = 8'h11; 8'he4: q_d = 8'h69; 8'he5: q_d = 8'hd9; 8'he6: q_d = 8'h8e; 8'he7: q_d = 8'h94;
      8'he8: q_d = 8'h9b; 8'he9: q_d = 8'h1e; 8'hea: q_d = 8'h87; 8'heb: q_d = 8'he9; 8'hec: q_d = 8'hce; 8'hed: q_d = 8'h55; 8'hee: q_d = 8'h28; 8'hef: q_d = 8'hdf;
      8'hf0: q_d = 8'h8c; 8'hf1: q_d = 8'ha1; 8'hf2: q_d = 8'h89; 8'hf3: q_d = 8'h0d; 8'hf4: q_d = 8'hbf; 8'hf5: q_d = 8'he6; 8'hf6: q_d = 8'h42; 8'hf7: q_d = 8'h68;
      8'hf8: q_d = 8'h41; 8'hf9: q_d = 8'h99; 8'hfa: q_d = 8'h2d; 8'hfb: q_d = 8'h0f; 8'hfc: q_d = 8'hb0; 8'hfd: q_d = 8'h54; 8'hfe: q_d = 8'hbb; 8'hff: q_d = 8'h16;
      default: q_d = 8'h00;
    endcase
  end

  // NOTE: the lookup register has no reset. It is pure datapath, only ever
  // read in the cycle after an address was driven, so a reset would buy
  // nothing but extra reset fan-out.
  always_ff @(posedge clk) begin
    q <= q_d;
  end

endmodule

// File: rtl/aes_subshift_enc.sv
// ---------------------------------------------------------------------------
// aes_subshift_enc
//   Iterative AES encryption SubBytes+ShiftRows engine. Accepts one 128-bit
//   state, runs it through four registered forward S-boxes one column per
//   cycle, writes each substituted column back with ShiftRows applied and
//   holds the finished state on a valid/ready output.
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : slave side of aes_subshift_enc_if
//             in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy
//   Timing: accept in cycle T, out_valid from T+6 until the out_ready cycle,
//   in_ready again the cycle after that (7 cycles per state minimum).
// ---------------------------------------------------------------------------
module aes_subshift_enc
  import aes_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  aes_subshift_enc_if.slave        bus
);

  fsm_state_e state_q, state_d;
  idx2_t      col_q, col_d;
  aes_state_t in_q;
  aes_state_t out_q;

  logic       load_in;
  logic       wb_en;
  idx2_t      wb_col;

  logic [BYTE_W-1:0] sbox_a [NUM_ROWS];
  logic [BYTE_W-1:0] sbox_q [NUM_ROWS];

  // -------------------------------------------------------------------------
  // Next-state logic. In LOOKUP, column col is being addressed while the
  // S-box registers hold column col-1, so write-back trails addressing by one
  // cycle; DRAIN exists only to write back the last column.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    load_in = 1'b0;
    wb_en   = 1'b0;
    wb_col  = col_q - 2'd1;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load_in = 1'b1;
          col_d   = FIRST_COL;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        wb_en = (col_q != FIRST_COL);
        col_d = col_q + 2'd1;
        if (col_q == LAST_COL) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wb_en   = 1'b1;
        wb_col  = LAST_COL;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so in_ready and
  // out_valid can never be high together.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_q;

  // -------------------------------------------------------------------------
  // Column addressing: row r's S-box always sees row r of column col_q.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      sbox_a[r] = in_q[slot(byte_idx(idx2_t'(r), col_q))];
    end
  end

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_sbox
    sbox_fwd u_sbox (
      .clk (clk),
      .a   (sbox_a[g]),
      .q   (sbox_q[g])
    );
  end

  // -------------------------------------------------------------------------
  // State, counter and data registers. Write-back places the S-box output
  // of (row r, column wb_col) at its ShiftRows destination.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= FIRST_COL;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (load_in) begin
        in_q <= bus.in_data;
      end
      if (wb_en) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          out_q[slot(shiftrows_idx(idx2_t'(r), wb_col))] <= sbox_q[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_subshift_enc.sv
// ---------------------------------------------------------------------------
// tb_aes_subshift_enc
//   Self-checking bench for aes_subshift_enc. Known-answer vectors from a
//   table, hand-timed corner sequences (backpressure, reset mid-operation)
//   and a randomized stream compared against a reference model that derives
//   the S-box from GF(2^8) inversion plus the affine map and applies
//   ShiftRows as a row rotation.
// ---------------------------------------------------------------------------
module tb_aes_subshift_enc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  aes_subshift_enc_if bus ();

  aes_subshift_enc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_tab [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    logic [127:0] mask;
  } vec_t;

  vec_t vecs [4];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
    return t;
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din);
    logic [7:0]   m_in  [4][4];  // [row][col]
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m_in[r][c] = din[127 - 8*(4*c + r) -: 8];
    res = '0;
    // Output row r is input row r rotated left by r, after substitution.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = sb_tab[m_in[r][(c + r) % 4]];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check_bit(input string what, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", what, act, exp, $time);
    end
  endtask

  task automatic check_word(input string what, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", what, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One state through the engine with out_ready held high, checking the
  // cycle-exact timing. Entered and left in an IDLE cycle.
  task automatic run_one(input string tag, input logic [127:0] din,
                         input logic [127:0] exp, input logic [127:0] mask);
    check_bit({tag, " in_ready@T"}, bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = rnd128();
    for (int k = 1; k <= 5; k++) begin
      check_bit($sformatf("%s out_valid@T+%0d", tag, k), bus.out_valid, 1'b0);
      check_bit($sformatf("%s busy@T+%0d", tag, k), bus.busy, 1'b1);
      tick();
    end
    check_bit({tag, " out_valid@T+6"}, bus.out_valid, 1'b1);
    check_bit({tag, " in_ready@T+6"}, bus.in_ready, 1'b0);
    check_word({tag, " out_data vs table"}, bus.out_data & mask, exp & mask);
    check_word({tag, " out_data vs model"}, bus.out_data, model(din));
    tick();
    check_bit({tag, " in_ready@T+7"}, bus.in_ready, 1'b1);
    check_bit({tag, " out_valid@T+7"}, bus.out_valid, 1'b0);
    check_bit({tag, " busy@T+7"}, bus.busy, 1'b0);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  initial begin
    logic [127:0] exp_q [$];
    logic [127:0] pend;
    logic [127:0] exp_w;
    int sent, got, cyc;

    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_math(8'(i));

    vecs[0] = '{din: 128'h0, dout: {16{8'h63}}, mask: {128{1'b1}}};
    vecs[1] = '{din: FIPS_IN, dout: FIPS_OUT, mask: {128{1'b1}}};
    vecs[2] = '{din: 128'h53112233445566778899aabbccddeeff,
                dout: {8'hed, 120'h0}, mask: {8'hff, 120'h0}};
    vecs[3] = '{din: {128{1'b1}}, dout: {16{8'h16}}, mask: {128{1'b1}}};

    // ---------------- reset ----------------
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_bit("reset in_ready", bus.in_ready, 1'b1);
    check_bit("reset out_valid", bus.out_valid, 1'b0);
    check_bit("reset busy", bus.busy, 1'b0);
    check_word("reset out_data", bus.out_data, 128'h0);

    // ---------------- known-answer table ----------------
    for (int i = 0; i < 4; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout, vecs[i].mask);
    end

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = FIPS_IN;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check_bit("bp out_valid@T+6", bus.out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = rnd128();
      check_bit($sformatf("bp out_valid hold%0d", i), bus.out_valid, 1'b1);
      check_bit($sformatf("bp in_ready hold%0d", i), bus.in_ready, 1'b0);
      check_word($sformatf("bp out_data hold%0d", i), bus.out_data, FIPS_OUT);
      tick();
    end
    // Output handshake with in_valid also high: must not be accepted.
    check_bit("bp out_valid final", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = {128{1'b1}};
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_bit("bp in_ready after", bus.in_ready, 1'b1);
    check_bit("bp out_valid after", bus.out_valid, 1'b0);
    check_bit("bp busy after", bus.busy, 1'b0);
    tick();
    check_bit("bp no back-to-back accept", bus.in_ready, 1'b1);
    check_word("bp out_data kept", bus.out_data, FIPS_OUT);

    // ---------------- reset during LOOKUP ----------------
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h00112233445566778899aabbccddeeff;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check_bit("mid-reset busy@T+3", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("mid-reset out_valid", bus.out_valid, 1'b0);
    check_word("mid-reset out_data", bus.out_data, 128'h0);
    check_bit("mid-reset in_ready", bus.in_ready, 1'b1);
    check_bit("mid-reset busy", bus.busy, 1'b0);
    run_one("post-reset", FIPS_IN, FIPS_OUT, {128{1'b1}});

    // ---------------- randomized stream ----------------
    sent = 0; got = 0; cyc = 0;
    pend = rnd128();
    bus.out_ready = 1'b0;
    while (got < 16 && cyc < 3000) begin
      bus.in_valid  = (sent < 16) && ($urandom_range(0, 2) != 0);
      bus.in_data   = bus.in_valid ? pend : rnd128();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      check_bit("stream in_ready&out_valid", bus.in_ready & bus.out_valid, 1'b0);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(pend));
        sent++;
        pend = rnd128();
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream unexpected output: got %h expected none", bus.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check_word($sformatf("stream out%0d", got), bus.out_data, exp_w);
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (got < 16) begin
      n_vec++;
      n_err++;
      $display("FAIL stream timeout: got %0d outputs expected 16", got);
    end
    repeat (3) tick();
    check_bit("stream idle at end", bus.busy, 1'b0);
    check_bit("stream no extra out_valid", bus.out_valid, 1'b0);
    check_word("stream sent count", 128'(sent), 128'd16);
    check_word("stream leftover expectations", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_subshift_enc.md
# aes_subshift_enc

Iterative AES encryption SubBytes+ShiftRows engine for the Nios II AES accelerator; forward counterpart of the inverse S-box path used by decryption. Accepts one 128-bit state over a valid/ready handshake and sweeps it through four registered forward S-box lookups, one column per cycle. It applies ShiftRows while writing results, then presents the 128-bit result on a valid/ready output. It sits between the AddRoundKey stage and the MixColumns stage of the encryption datapath.

## Interface
- No parameters; widths fixed by AES (128-bit state, 8-bit bytes).
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a state to process
- in_ready  out  1  block can accept a state (high only in IDLE)
- in_data  in  128  input state, FIPS-197 byte order: byte 0 = [127:120], column c = bytes 4c..4c+3, row r of column c = byte 4c+r
- out_valid  out  1  out_data holds a finished state
- out_ready  in  1  downstream accepts out_data
- out_data  out  128  SubBytes then ShiftRows of the input, same byte order
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOOKUP, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data into the input register, clear col counter, go to LOOKUP.
- LOOKUP:
  - Present the 4 bytes of column col to the 4 S-box instances.
  - Write back the S-box outputs of column col-1 when col>0.
  - col increments 0..3; after col=3 go to DRAIN.
- DRAIN: write back column 3 outputs; go to DONE.
- Write-back applies ShiftRows: S-box output for input row r, column c goes to out_data row r, column (c - r) mod 4. Row 0 is unshifted; row r rotates left by r.
- DONE:
  - out_valid=1; out_data stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored outside IDLE.
- No back-to-back acceptance in the cycle out_ready completes; the next input is accepted in the following IDLE cycle.
- Reset values:
  - state=IDLE, col=0, in_ready=1, out_valid=0, busy=0.
  - out_data=128'h0; input register=0.
- Reset asserted mid-operation: the same reset values apply in the next cycle. The partial state is discarded and no out_valid pulse occurs.

## Timing
- Input handshake in cycle T (IDLE, in_valid=1).
- Column k address is presented in cycle T+1+k; its registered lookup is available at T+2+k and written at the end of T+2+k.
- out_valid=1 first in cycle T+6 and held until the out_ready cycle inclusive.
- in_ready=1 again in the cycle after the output handshake, so the minimum period is 7 cycles per state.
- out_ready high before DONE has no effect; out_ready is sampled only in DONE.
- in_ready and out_valid are never high in the same cycle.

## Structure
- Shared package aes_pkg:
  - state encoding typedef (IDLE/LOOKUP/DRAIN/DONE);
  - byte/column index constants;
  - shiftrows index function (row, col) -> destination byte index, also reused by the inverse engine.
- One sub-module, sbox_fwd:
  - inputs clk, a[7:0]; output q[7:0];
  - registered (1-cycle) forward AES S-box lookup, 256-entry case.
  - Instantiated 4 times, one per row.
- The FSM, counter, input/output registers and ShiftRows mapping live in aes_subshift_enc.

## Test plan
- Reset, then in_data=0 with out_ready=1 -> out_valid at T+6, out_data=128'h63636363636363636363636363636363, in_ready=1 at T+7.
- FIPS-197 App. B round 1, in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5.
- Byte-map check: in_data=00112233445566778899aabbccddeeff with 0x53 at byte 0 -> byte 0 of out_data = 0xed. All-0xff input -> all 0x16.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 -> IDLE the next cycle.
- Reset at T+3 during LOOKUP -> next cycle out_valid=0, out_data=0, in_ready=1, busy=0. A new state accepted afterwards produces the correct result.
- Streaming: 16 random states with random in_valid/out_ready gaps -> every output matches the reference model (forward S-box + ShiftRows), in order, with no drops or duplicates.
